// File: rtl/arb_mux_rr_pkg.sv
// rtl/arb_mux_rr_pkg.sv - shared constants for the round-robin packet mux
// Packet width default and arbitration mode encodings.
package arb_mux_rr_pkg;
   localparam int DW_DEFAULT = 99;
   localparam int RR_MODE    = 1;
   localparam int FIXED_MODE = 0;
endpackage

// File: rtl/arb_rr_onehot.sv
// rtl/arb_rr_onehot.sv - combinational one-hot arbiter, round-robin or fixed priority
// Requests at or above ptr are searched first; the upper half catches the wrap.
module arb_rr_onehot
   import arb_mux_rr_pkg::*;
#(
   parameter int N  = 4,
   parameter int RR = RR_MODE
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] ptr,
   input  logic         en,
   output logic [N-1:0] grant
);

   logic [N-1:0]   w_masked;
   logic [2*N-1:0] w_dbl;
   logic [2*N-1:0] w_low;

   always_comb begin
      w_masked = '0;
      if (RR == RR_MODE) begin
         w_masked = req & ~(ptr - N'(1));
      end
   end

   // Lowest set bit of {req, masked}: a masked hit wins, otherwise plain req.
   assign w_dbl = {req, w_masked};
   assign w_low = w_dbl & (~w_dbl + (2*N)'(1));
   assign grant = en ? (w_low[N-1:0] | w_low[2*N-1:N]) : '0;

endmodule

// File: rtl/arb_mux_rr.sv
// rtl/arb_mux_rr.sv - N-channel arbitrated packet mux with a registered output stage
// Holds the priority pointer, the AND-OR select and the backpressured output register.
module arb_mux_rr
   import arb_mux_rr_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int N  = 4,
   parameter int RR = RR_MODE
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [N-1:0]    in_access,
   input  logic [N*DW-1:0] in_packet,
   output logic [N-1:0]    in_wait,
   output logic            out_access,
   output logic [DW-1:0]   out_packet,
   input  logic            out_wait
);

   logic [N-1:0]  r_ptr;
   logic          r_out_access;
   logic [DW-1:0] r_out_packet;
   logic          w_ready;
   logic [N-1:0]  w_grant;
   logic [N-1:0]  w_ptr_next;
   logic [DW-1:0] w_sel_packet;

   assign w_ready = ~r_out_access | ~out_wait;

   arb_rr_onehot #(.N(N), .RR(RR)) u_arb (
      .req   (in_access),
      .ptr   (r_ptr),
      .en    (w_ready),
      .grant (w_grant)
   );

   assign in_wait = in_access & ~w_grant;

   always_comb begin
      w_sel_packet = '0;
      for (int i = 0; i < N; i++) begin
         w_sel_packet = w_sel_packet | ({DW{w_grant[i]}} & in_packet[i*DW +: DW]);
      end
   end

   // Next search starts just above the channel that won.
   generate
      if (N == 1) begin : g_ptr_one
         assign w_ptr_next = 1'b1;
      end else begin : g_ptr_rot
         assign w_ptr_next = {w_grant[N-2:0], w_grant[N-1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_ptr <= N'(1);
      end else if ((RR == RR_MODE) && (|w_grant)) begin
         r_ptr <= w_ptr_next;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_out_access <= 1'b0;
         r_out_packet <= '0;
      end else if (w_ready) begin
         r_out_access <= |w_grant;
         if (|w_grant) begin
            r_out_packet <= w_sel_packet;
         end
      end
   end

   assign out_access = r_out_access;
   assign out_packet = r_out_packet;

endmodule
